// File: rtl/captura_camera.sv
`default_nettype none
// =============================================================================
// captura_camera : samples an 8-bit PCLK/HREF/VSYNC camera bus, one frame per start
// Rev 1.0
// =============================================================================
module captura_camera #(
    parameter int H_PIXELS = 320,
    parameter int V_LINES  = 240
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic       iniciar,
    input  logic       cam_pclk,
    input  logic       cam_href,
    input  logic       cam_vsync,
    input  logic [7:0] cam_data,
    output logic [7:0] byte_out,
    output logic       byte_enable,
    output logic       pixel_valid,
    output logic [8:0] coluna,
    output logic [7:0] linha,
    output logic       fim_quadro,
    output logic       ocupado,
    output logic       erro
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ESPERA  = 2'd1,
        CAPTURA = 2'd2,
        FIM     = 2'd3
    } state_t;

    localparam logic [9:0] c_H_FULL = 10'(H_PIXELS);
    localparam logic [8:0] c_V_FULL = 9'(V_LINES);

    // bits [1:0] are the synchronizer, bit [2] the delayed copy for edge detection
    logic [2:0] r_pclk_sync;
    logic [2:0] r_href_sync;
    logic [2:0] r_vsync_sync;
    logic [7:0] r_data_s1;
    logic [7:0] r_data_s2;

    state_t     r_state;
    logic [9:0] r_col;
    logic [8:0] r_line;
    logic       r_fase;
    logic       r_pend;
    logic [8:0] r_pend_col;
    logic [7:0] r_pend_line;

    logic [7:0] r_byte;
    logic       r_byte_en;
    logic       r_pix_valid;
    logic [8:0] r_coluna;
    logic [7:0] r_linha;
    logic       r_fim;
    logic       r_ocupado;
    logic       r_erro;

    logic       w_pclk_rise;
    logic       w_href_fall;
    logic       w_vsync_rise;
    logic       w_vsync_fall;
    logic       w_line_full;
    logic       w_frame_full;
    logic [8:0] w_line_next;
    logic [8:0] w_lines_done;

    assign w_pclk_rise  = r_pclk_sync[1] & ~r_pclk_sync[2];
    assign w_href_fall  = ~r_href_sync[1] & r_href_sync[2];
    assign w_vsync_rise = r_vsync_sync[1] & ~r_vsync_sync[2];
    assign w_vsync_fall = ~r_vsync_sync[1] & r_vsync_sync[2];
    assign w_line_full  = (r_col == c_H_FULL);
    assign w_frame_full = (r_line >= c_V_FULL);
    assign w_line_next  = (r_line == c_V_FULL) ? r_line : r_line + 9'd1;
    // a line ending in the same cycle as vsync rises still counts toward the frame
    assign w_lines_done = w_href_fall ? w_line_next : r_line;

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_pclk_sync  <= '0;
            r_href_sync  <= '0;
            r_vsync_sync <= '0;
            r_data_s1    <= '0;
            r_data_s2    <= '0;
            r_state      <= OCIOSO;
            r_col        <= '0;
            r_line       <= '0;
            r_fase       <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_col   <= '0;
            r_pend_line  <= '0;
            r_byte       <= '0;
            r_byte_en    <= 1'b0;
            r_pix_valid  <= 1'b0;
            r_coluna     <= '0;
            r_linha      <= '0;
            r_fim        <= 1'b0;
            r_ocupado    <= 1'b0;
            r_erro       <= 1'b0;
        end else begin
            r_pclk_sync  <= {r_pclk_sync[1:0], cam_pclk};
            r_href_sync  <= {r_href_sync[1:0], cam_href};
            r_vsync_sync <= {r_vsync_sync[1:0], cam_vsync};
            r_data_s1    <= cam_data;
            r_data_s2    <= r_data_s1;

            r_byte_en    <= 1'b0;
            r_pend       <= 1'b0;
            r_fim        <= 1'b0;
            r_pix_valid  <= r_pend;
            if (r_pend) begin
                r_coluna <= r_pend_col;
                r_linha  <= r_pend_line;
            end

            case (r_state)
                OCIOSO: begin
                    if (iniciar) begin
                        r_erro    <= 1'b0;
                        r_col     <= '0;
                        r_line    <= '0;
                        r_fase    <= 1'b0;
                        r_ocupado <= 1'b1;
                        r_state   <= ESPERA;
                    end
                end
                ESPERA: begin
                    if (w_vsync_fall) begin
                        r_state <= CAPTURA;
                    end
                end
                CAPTURA: begin
                    if (w_pclk_rise && r_href_sync[1]) begin
                        if (w_line_full || w_frame_full) begin
                            r_erro <= 1'b1;
                        end else begin
                            r_byte    <= r_data_s2;
                            r_byte_en <= 1'b1;
                            r_fase    <= ~r_fase;
                            if (r_fase) begin
                                r_pend      <= 1'b1;
                                r_pend_col  <= r_col[8:0];
                                r_pend_line <= r_line[7:0];
                                r_col       <= r_col + 10'd1;
                            end
                        end
                    end
                    if (w_href_fall) begin
                        if (!w_line_full || r_fase) begin
                            r_erro <= 1'b1;
                        end
                        r_col  <= '0;
                        r_fase <= 1'b0;
                        r_line <= w_line_next;
                    end
                    if (w_vsync_rise) begin
                        if (w_lines_done != c_V_FULL) begin
                            r_erro <= 1'b1;
                        end
                        r_fim   <= 1'b1;
                        r_state <= FIM;
                    end
                end
                FIM: begin
                    r_ocupado <= 1'b0;
                    r_state   <= OCIOSO;
                end
                default: r_state <= OCIOSO;
            endcase
        end
    end

    assign byte_out    = r_byte;
    assign byte_enable = r_byte_en;
    assign pixel_valid = r_pix_valid;
    assign coluna      = r_coluna;
    assign linha       = r_linha;
    assign fim_quadro  = r_fim;
    assign ocupado     = r_ocupado;
    assign erro        = r_erro;

endmodule
`default_nettype wire

// File: tb/tb_captura_camera.sv
`default_nettype none
// tb_captura_camera : random camera frames checked against a queue-based capture model
module tb_captura_camera;

    localparam int H = 4;
    localparam int V = 2;

    logic       clock     = 1'b0;
    logic       clear_n   = 1'b0;
    logic       iniciar   = 1'b0;
    logic       cam_pclk  = 1'b0;
    logic       cam_href  = 1'b0;
    logic       cam_vsync = 1'b1;
    logic [7:0] cam_data  = 8'h00;
    logic [7:0] byte_out;
    logic       byte_enable;
    logic       pixel_valid;
    logic [8:0] coluna;
    logic [7:0] linha;
    logic       fim_quadro;
    logic       ocupado;
    logic       erro;

    always #5 clock = ~clock;

    captura_camera #(.H_PIXELS(H), .V_LINES(V)) dut (
        .clock      (clock),
        .clear_n    (clear_n),
        .iniciar    (iniciar),
        .cam_pclk   (cam_pclk),
        .cam_href   (cam_href),
        .cam_vsync  (cam_vsync),
        .cam_data   (cam_data),
        .byte_out   (byte_out),
        .byte_enable(byte_enable),
        .pixel_valid(pixel_valid),
        .coluna     (coluna),
        .linha      (linha),
        .fim_quadro (fim_quadro),
        .ocupado    (ocupado),
        .erro       (erro)
    );

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  exp_bytes[$];
    logic [32:0] exp_pix[$];
    int          n_be, n_pv, n_fim;
    int          exp_be, exp_pv;
    bit          exp_err;
    logic [15:0] q = 16'h0;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observes strobes; q models the downstream 16-bit pixel register
    always @(negedge clock) begin
        if (pixel_valid) begin
            n_pv++;
            if (exp_pix.size() == 0) check_value("pv_extra", pixel_valid, 0);
            else check_value("pixel", {coluna, linha, q}, exp_pix.pop_front());
        end
        if (byte_enable) begin
            n_be++;
            check_value("be_busy", ocupado, 1);
            if (exp_bytes.size() == 0) check_value("be_extra", byte_enable, 0);
            else check_value("byte", byte_out, exp_bytes.pop_front());
            q = {q[7:0], byte_out};
        end
        if (fim_quadro) n_fim++;
    end

    task automatic reset_model();
        exp_bytes.delete();
        exp_pix.delete();
        n_be = 0; n_pv = 0; n_fim = 0;
        exp_be = 0; exp_pv = 0; exp_err = 1'b0;
    endtask

    task automatic pulse_start(input bit expect_accept);
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        check_value("start_busy", ocupado, 1);
        if (expect_accept) check_value("start_err_clr", erro, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit pulse);
        cam_pclk = 1'b0;
        cam_data = b;
        cam_href = 1'b1;
        iniciar  = pulse;
        @(negedge clock);
        iniciar  = 1'b0;
        @(negedge clock);
        cam_pclk = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic send_line(input int n, input int li, input bit cap, input int pulse_at, input bit fixed);
        logic [7:0] b, prev;
        prev = 8'h00;
        for (int k = 0; k < n; k++) begin
            b = fixed ? 8'(16 * (li + 1) + k) : 8'($urandom);
            if (cap && li < V && k < 2 * H) begin
                exp_bytes.push_back(b);
                exp_be++;
                if (k % 2 == 1) begin
                    exp_pix.push_back({9'(k / 2), 8'(li), prev, b});
                    exp_pv++;
                end
            end
            send_byte(b, k == pulse_at);
            prev = b;
        end
        if (cap && (n != 2 * H || li >= V)) exp_err = 1'b1;
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        repeat (6) @(negedge clock);
    endtask

    task automatic run_frame(input int nl, input int l0, input int l1, input int l2,
                             input bit cap, input int pulse_at, input bit fixed);
        int lens[3];
        lens = '{l0, l1, l2};
        cam_vsync = 1'b1;
        repeat (6) @(negedge clock);
        cam_vsync = 1'b0;
        repeat (6) @(negedge clock);
        for (int li = 0; li < nl; li++)
            send_line(lens[li], li, cap, (li == 0) ? pulse_at : -1, fixed);
        if (cap && nl != V) exp_err = 1'b1;
        cam_vsync = 1'b1;
        repeat (12) @(negedge clock);
    endtask

    task automatic end_frame(input int fims);
        check_value("n_bytes", n_be, exp_be);
        check_value("n_pixels", n_pv, exp_pv);
        check_value("n_fim", n_fim, fims);
        check_value("erro", erro, exp_err);
        check_value("idle_after", ocupado, 0);
    endtask

    initial begin
        reset_model();
        // reset with the camera bus toggling
        for (int i = 0; i < 3; i++) begin
            cam_pclk  = ~cam_pclk;
            cam_href  = ~cam_href;
            cam_vsync = ~cam_vsync;
            cam_data  = 8'($urandom);
            @(negedge clock);
        end
        check_value("rst_out", {byte_out, byte_enable, pixel_valid, coluna, linha, fim_quadro, erro}, 0);
        check_value("rst_busy", ocupado, 0);
        clear_n = 1'b1;
        cam_pclk = 1'b0; cam_href = 1'b0; cam_vsync = 1'b1;
        run_frame(1, 8, 0, 0, 0, -1, 0);
        check_value("idle_no_start", ocupado, 0);
        check_value("idle_no_bytes", n_be, 0);

        // nominal frame with fixed data; first pixel Q must be 0x1011
        reset_model();
        pulse_start(1);
        run_frame(2, 8, 8, 0, 1, -1, 1);
        end_frame(1);

        // random frame with a second iniciar mid-frame that must be ignored
        reset_model();
        pulse_start(1);
        run_frame(2, 8, 8, 0, 1, 3, 0);
        end_frame(1);

        // start while a frame is already in progress
        reset_model();
        cam_vsync = 1'b1;
        repeat (6) @(negedge clock);
        cam_vsync = 1'b0;
        repeat (6) @(negedge clock);
        send_line(8, 0, 0, 3, 0);
        send_line(8, 1, 0, -1, 0);
        cam_vsync = 1'b1;
        repeat (12) @(negedge clock);
        check_value("mid_no_bytes", n_be, 0);
        check_value("mid_no_fim", n_fim, 0);
        check_value("mid_waiting", ocupado, 1);
        run_frame(2, 8, 8, 0, 1, -1, 0);
        end_frame(1);

        // short line, then erro must clear on the next start
        reset_model();
        pulse_start(1);
        run_frame(2, 8, 7, 0, 1, -1, 0);
        end_frame(1);

        // long line
        reset_model();
        pulse_start(1);
        run_frame(2, 10, 8, 0, 1, -1, 0);
        end_frame(1);

        // extra line
        reset_model();
        pulse_start(1);
        run_frame(3, 8, 8, 8, 1, -1, 0);
        end_frame(1);

        // reset after the 5th byte aborts the capture
        reset_model();
        pulse_start(1);
        cam_vsync = 1'b1;
        repeat (6) @(negedge clock);
        cam_vsync = 1'b0;
        repeat (6) @(negedge clock);
        begin
            logic [7:0] b, prev;
            prev = 8'h00;
            for (int k = 0; k < 5; k++) begin
                b = 8'($urandom);
                exp_bytes.push_back(b);
                exp_be++;
                if (k % 2 == 1) begin
                    exp_pix.push_back({9'(k / 2), 8'd0, prev, b});
                    exp_pv++;
                end
                send_byte(b, 0);
                prev = b;
            end
        end
        repeat (3) @(negedge clock);
        clear_n = 1'b0;
        @(negedge clock);
        clear_n = 1'b1;
        for (int k = 0; k < 3; k++) send_byte(8'($urandom), 0);
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        repeat (6) @(negedge clock);
        cam_vsync = 1'b1;
        repeat (12) @(negedge clock);
        end_frame(0);

        // random frames with random line counts and lengths
        for (int f = 0; f < 4; f++) begin
            int nl;
            nl = $urandom_range(1, 3);
            reset_model();
            pulse_start(1);
            run_frame(nl, $urandom_range(6, 10), $urandom_range(6, 10), $urandom_range(6, 10), 1, -1, 0);
            end_frame(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/captura_camera.md
Name: captura_camera

Overview:
- Upstream feeder of the 16-bit pixel register.
- Samples the camera's 8-bit bus (PCLK/HREF/VSYNC) in the system clock domain and captures exactly one frame per start request.
- Emits each byte with a one-cycle enable that drives the pixel register's D/enable.
- Flags each completed pixel (byte pair) with its column/line coordinates, reports end of frame, and flags framing errors.

Parameters:
- H_PIXELS, 320, pixels per line (2 bytes each), 2..512
- V_LINES, 240, lines per frame, 1..256

Ports:
- clock  in  1  system clock, ≥4x camera PCLK
- clear_n  in  1  synchronous active-low reset
- iniciar  in  1  start one-frame capture (level sampled when idle)
- cam_pclk  in  1  camera pixel clock (asynchronous)
- cam_href  in  1  camera line valid (asynchronous)
- cam_vsync  in  1  camera frame sync, high between frames (asynchronous)
- cam_data  in  8  camera data bus (asynchronous)
- byte_out  out  8  captured byte; connects to the pixel register's D
- byte_enable  out  1  one-cycle strobe; connects to the pixel register's enable
- pixel_valid  out  1  one-cycle; the pixel register's Q holds a complete pixel this cycle
- coluna  out  9  column of the pixel flagged by pixel_valid
- linha  out  8  line of the pixel flagged by pixel_valid
- fim_quadro  out  1  one-cycle end-of-frame pulse
- ocupado  out  1  high from accepted start until fim_quadro
- erro  out  1  sticky framing error, cleared on the next accepted start

Behaviour:
- One clock domain. Reset is synchronous, active-low: when clear_n=0 at a clock rising edge, every register is cleared.
- Reset values:
  - all outputs 0;
  - state OCIOSO;
  - column, line and byte-phase counters 0;
  - synchronizers 0.
- Reset mid-capture aborts the capture immediately; no fim_quadro is emitted.
- Synchronization:
  - cam_pclk, cam_href, cam_vsync and cam_data each pass through 2 flip-flops.
  - Edges are detected on the synchronized signals against a third delayed copy.
  - A PCLK rise is a synchronized 0→1 transition; cam_data is taken from the same sync stage.
- States:
  - OCIOSO: ocupado=0. If iniciar=1, clear erro and the counters, then go to ESPERA.
  - ESPERA: ocupado=1. Wait for a synchronized falling edge of vsync (start of frame), then go to CAPTURA. Ignore HREF and PCLK in this state.
  - CAPTURA: per-event rules are listed below.
  - FIM: fim_quadro=1 for exactly one cycle, then go to OCIOSO. ocupado drops in the cycle after FIM.
- CAPTURA, PCLK rise with href=1 and line not yet full (byte count < 2*H_PIXELS):
  - byte_out ← data and byte_enable=1 in the next cycle;
  - fase toggles.
- CAPTURA, pixel completion (fase was 1 at that PCLK rise):
  - pixel_valid=1 two cycles after the rise, i.e. the cycle after the second byte_enable;
  - coluna/linha hold that pixel's coordinates during pixel_valid;
  - the column then increments.
- CAPTURA, PCLK rise with href=1 and line already full:
  - byte dropped, no strobe, erro ← 1.
- CAPTURA, href falling edge:
  - if column ≠ H_PIXELS or fase=1: erro ← 1;
  - column ← 0, fase ← 0, line increments (saturates at V_LINES).
  - Bytes of lines at index ≥ V_LINES are dropped and erro ← 1.
- CAPTURA, vsync rising edge:
  - if completed line count ≠ V_LINES: erro ← 1;
  - go to FIM.
  - If href fall and vsync rise occur in the same cycle, process the href fall first.
- iniciar is ignored while ocupado=1.
- erro is sticky; it is only cleared by reset or an accepted iniciar.
- byte_enable and pixel_valid are never asserted outside CAPTURA, except a pixel_valid still in flight (one cycle) when CAPTURA ends.

Test Plan:
- Reset: hold clear_n=0 for 3 cycles while cam_* toggle → all outputs 0, ocupado=0. Release → stays in OCIOSO without iniciar.
- Nominal frame, H_PIXELS=4, V_LINES=2, PCLK = clock/4:
  - Stimulus: iniciar, vsync high→low, two lines of 8 bytes 0x10..0x17 and 0x20..0x27, then vsync rise.
  - Required response:
    - 16 byte_enables;
    - 8 pixel_valids, with coordinates (0,0)..(3,0),(0,1)..(3,1);
    - for the first pixel, the register Q equals 0x1011;
    - one fim_quadro; erro=0; ocupado low afterwards.
- Mid-frame start: iniciar asserted while vsync is already low and a line is in progress → no bytes captured until the next vsync fall. The next frame captures normally.
- Short line: second line has only 7 bytes → erro=1 after that href fall; capture still ends with fim_quadro. erro clears on the next iniciar.
- Long line and extra line:
  - a 10-byte line → bytes 9 and 10 produce no byte_enable, erro=1;
  - a frame with 3 lines (V_LINES=2) → the third line is dropped, erro=1.
- Reset mid-CAPTURA: clear_n=0 for 1 cycle after the 5th byte → no further strobes, no fim_quadro, state OCIOSO. iniciar ignored while ocupado=1: a second pulse mid-frame causes no restart.
